mips_regwrite_arbiter: RTL and testbench

Shares the single write port of the 8×32-bit MIPS register file (`mips_registers`) between two writeback requesters. Requester A is the ALU writeback and requester B is the load/memory writeback. Each requester hands off through a valid/ready handshake into a one-entry holding slot. The arbiter issues at most one registered write per cycle onto `write_data`/`write_reg`/`signal_reg_write`, and exports a pending-write scoreboard that decode uses for stall detection.

---
 rtl/mips_regwrite_pkg.sv | 21 ++
 rtl/mips_regwrite_arbiter_if.sv | 33 +++
 rtl/mips_regwrite_arbiter_slot.sv | 25 ++
 rtl/mips_regwrite_arbiter.sv | 115 +++++++++++
 tb/tb_mips_regwrite_arbiter.sv | 169 ++++++++++++++++
 5 files changed

// File: rtl/mips_regwrite_pkg.sv
// Shared widths, requester ids and the holding-slot record for the
// register-file write-port arbiter.
package mips_regwrite_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 3;
    localparam int NUM_REGS = 1 << ADDR_W;
    localparam int NUM_REQ  = 2;

    typedef enum logic {
        REQ_A = 1'b0,
        REQ_B = 1'b1
    } req_id_t;

    typedef struct packed {
        logic              full;
        logic [ADDR_W-1:0] dst;
        logic [DATA_W-1:0] data;
    } wr_slot_t;

endpackage

// File: rtl/mips_regwrite_arbiter_if.sv
// Writeback requester handshakes plus the register-file write port and
// the pending-write scoreboard.
interface mips_regwrite_arbiter_if;
    import mips_regwrite_pkg::*;

    logic                a_valid;
    logic                a_ready;
    logic [ADDR_W-1:0]   a_reg;
    logic [DATA_W-1:0]   a_data;
    logic                b_valid;
    logic                b_ready;
    logic [ADDR_W-1:0]   b_reg;
    logic [DATA_W-1:0]   b_data;
    logic [DATA_W-1:0]   write_data;
    logic [ADDR_W-1:0]   write_reg;
    logic                signal_reg_write;
    logic [NUM_REGS-1:0] pending;

    modport slave (
        input  a_valid, a_reg, a_data,
        input  b_valid, b_reg, b_data,
        output a_ready, b_ready,
        output write_data, write_reg, signal_reg_write, pending
    );

    modport master (
        output a_valid, a_reg, a_data,
        output b_valid, b_reg, b_data,
        input  a_ready, b_ready,
        input  write_data, write_reg, signal_reg_write, pending
    );

endinterface

// File: rtl/mips_regwrite_arbiter_slot.sv
// One-entry writeback holding register; load has priority over clear so a
// slot can drain and refill at the same edge.
module mips_regwrite_slot
    import mips_regwrite_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              clear,
    input  logic [ADDR_W-1:0] dst_in,
    input  logic [DATA_W-1:0] data_in,
    output wr_slot_t          slot
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slot <= '0;
        end else if (load) begin
            slot <= '{full: 1'b1, dst: dst_in, data: data_in};
        end else if (clear) begin
            slot.full <= 1'b0;
        end
    end

endmodule

// File: rtl/mips_regwrite_arbiter.sv
// Two-requester arbiter for the single register-file write port: holding
// slots, age/round-robin grant, registered output stage, pending scoreboard.
module mips_regwrite_arbiter
    import mips_regwrite_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset,
    mips_regwrite_arbiter_if.slave   bus
);

    wr_slot_t             slot [NUM_REQ];
    logic [NUM_REQ-1:0]   valid;
    logic [NUM_REQ-1:0]   ready;
    logic [NUM_REQ-1:0]   acc;
    logic [NUM_REQ-1:0]   grant;
    logic [NUM_REQ-1:0][ADDR_W-1:0] dst_in;
    logic [NUM_REQ-1:0][DATA_W-1:0] data_in;

    logic                 a_older;
    logic                 tie;
    req_id_t              last_grant;

    logic                 wr_en_q;
    logic [ADDR_W-1:0]    wr_reg_q;
    logic [DATA_W-1:0]    wr_data_q;
    logic [NUM_REGS-1:0]  pending_c;

    assign valid   = {bus.b_valid, bus.a_valid};
    assign dst_in  = {bus.b_reg,   bus.a_reg};
    assign data_in = {bus.b_data,  bus.a_data};

    // Ready depends only on registered state, never on the valids.
    assign ready = ~{slot[1].full, slot[0].full} | grant;
    assign acc   = valid & ready;

    generate
        for (genvar i = 0; i < NUM_REQ; i++) begin : g_slot
            mips_regwrite_slot u_slot (
                .clk     (clk),
                .reset   (reset),
                .load    (acc[i]),
                .clear   (grant[i]),
                .dst_in  (dst_in[i]),
                .data_in (data_in[i]),
                .slot    (slot[i])
            );
        end
    endgenerate

    // Both full: older wins; same-edge loads fall back to round-robin.
    always_comb begin
        grant = '0;
        case ({slot[1].full, slot[0].full})
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11: begin
                if (tie) grant = (last_grant == REQ_B) ? 2'b01 : 2'b10;
                else     grant = a_older ? 2'b01 : 2'b10;
            end
            default: grant = '0;
        endcase
    end

    // a_older is only meaningful while both slots are full, so a lone load
    // simply marks the other (still-held) slot as the older one.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_older    <= 1'b0;
            tie        <= 1'b0;
            last_grant <= REQ_B;
        end else begin
            if (|grant) last_grant <= grant[0] ? REQ_A : REQ_B;
            if (&acc) begin
                tie <= 1'b1;
            end else if (acc[0]) begin
                tie     <= 1'b0;
                a_older <= 1'b0;
            end else if (acc[1]) begin
                tie     <= 1'b0;
                a_older <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_en_q   <= 1'b0;
            wr_reg_q  <= '0;
            wr_data_q <= '0;
        end else begin
            wr_en_q <= |grant;
            if (|grant) begin
                wr_reg_q  <= grant[0] ? slot[0].dst  : slot[1].dst;
                wr_data_q <= grant[0] ? slot[0].data : slot[1].data;
            end
        end
    end

    always_comb begin
        pending_c = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            pending_c[r] = (slot[0].full && slot[0].dst == ADDR_W'(r)) ||
                           (slot[1].full && slot[1].dst == ADDR_W'(r)) ||
                           (wr_en_q      && wr_reg_q    == ADDR_W'(r));
        end
    end

    assign bus.a_ready          = ready[0];
    assign bus.b_ready          = ready[1];
    assign bus.signal_reg_write = wr_en_q;
    assign bus.write_reg        = wr_reg_q;
    assign bus.write_data       = wr_data_q;
    assign bus.pending          = pending_c;

endmodule

// File: tb/tb_mips_regwrite_arbiter.sv
// Directed vector table plus hand-written sequences for the write-port arbiter.
module tb_mips_regwrite_arbiter;
    import mips_regwrite_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    mips_regwrite_arbiter_if bus ();

    mips_regwrite_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    typedef struct {
        logic        av;
        logic [2:0]  ar;
        logic [31:0] ad;
        logic        bv;
        logic [2:0]  br;
        logic [31:0] bd;
        logic        srw;
        logic [2:0]  wr;
        logic [31:0] wd;
        logic [7:0]  pend;
        logic        ardy;
        logic        brdy;
    } vec_t;

    localparam int NV = 23;
    vec_t vecs [NV];

    function automatic vec_t mk(logic av, logic [2:0] ar, logic [31:0] ad,
                                logic bv, logic [2:0] br, logic [31:0] bd,
                                logic srw, logic [2:0] wr, logic [31:0] wd,
                                logic [7:0] pend, logic ardy, logic brdy);
        vec_t v;
        v.av = av; v.ar = ar; v.ad = ad; v.bv = bv; v.br = br; v.bd = bd;
        v.srw = srw; v.wr = wr; v.wd = wd; v.pend = pend;
        v.ardy = ardy; v.brdy = brdy;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.a_valid = 1'b0; bus.a_reg = '0; bus.a_data = '0;
        bus.b_valid = 1'b0; bus.b_reg = '0; bus.b_data = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    initial begin
        logic [31:0] exp_seq [8];
        logic        acc_a, acc_b, prev_both_low;
        int          a_n, b_n, commits;

        // Rows: inputs before an edge, expected outputs just after it.
        vecs[0]  = mk(1,1,32'h11, 1,2,32'h22, 0,0,32'h0,        8'h06, 1,0);
        vecs[1]  = mk(0,0,0,      0,0,0,      1,1,32'h11,       8'h06, 1,1);
        vecs[2]  = mk(0,0,0,      0,0,0,      1,2,32'h22,       8'h04, 1,1);
        vecs[3]  = mk(0,0,0,      0,0,0,      0,2,32'h22,       8'h00, 1,1);
        vecs[4]  = mk(1,4,32'hCE7FFFF0, 0,0,0, 0,2,32'h22,      8'h10, 1,1);
        vecs[5]  = mk(0,0,0,      0,0,0,      1,4,32'hCE7FFFF0, 8'h10, 1,1);
        vecs[6]  = mk(0,0,0,      0,0,0,      0,4,32'hCE7FFFF0, 8'h00, 1,1);
        vecs[7]  = mk(1,3,32'h33, 1,6,32'h66, 0,4,32'hCE7FFFF0, 8'h48, 0,1);
        vecs[8]  = mk(0,0,0,      1,5,32'hB,  1,6,32'h66,       8'h68, 1,0);
        vecs[9]  = mk(1,5,32'hA,  0,0,0,      1,3,32'h33,       8'h28, 0,1);
        vecs[10] = mk(0,0,0,      0,0,0,      1,5,32'hB,        8'h20, 1,1);
        vecs[11] = mk(0,0,0,      0,0,0,      1,5,32'hA,        8'h20, 1,1);
        vecs[12] = mk(0,0,0,      0,0,0,      0,5,32'hA,        8'h00, 1,1);
        vecs[13] = mk(1,0,32'h100, 0,0,0,     0,5,32'hA,        8'h01, 1,1);
        for (int i = 1; i < 8; i++)
            vecs[13+i] = mk(1, 3'(i), 32'h100 + i, 0,0,0,
                            1, 3'(i-1), 32'h100 + i - 1,
                            8'((1 << i) | (1 << (i-1))), 1,1);
        vecs[21] = mk(0,0,0,      0,0,0,      1,7,32'h107,      8'h80, 1,1);
        vecs[22] = mk(0,0,0,      0,0,0,      0,7,32'h107,      8'h00, 1,1);

        idle_inputs();
        #12;
        check("reset_srw",   bus.signal_reg_write, 0);
        check("reset_wdata", bus.write_data, 0);
        check("reset_wreg",  bus.write_reg, 0);
        check("reset_pend",  bus.pending, 0);
        check("reset_ready", {bus.a_ready, bus.b_ready}, 2'b11);
        @(posedge clk); #1;
        reset = 1'b0;

        for (int k = 0; k < NV; k++) begin
            bus.a_valid = vecs[k].av; bus.a_reg = vecs[k].ar; bus.a_data = vecs[k].ad;
            bus.b_valid = vecs[k].bv; bus.b_reg = vecs[k].br; bus.b_data = vecs[k].bd;
            @(posedge clk); #1;
            check($sformatf("v%0d_srw", k),   bus.signal_reg_write, vecs[k].srw);
            check($sformatf("v%0d_wreg", k),  bus.write_reg, vecs[k].wr);
            check($sformatf("v%0d_wdata", k), bus.write_data, vecs[k].wd);
            check($sformatf("v%0d_pend", k),  bus.pending, vecs[k].pend);
            check($sformatf("v%0d_ready", k), {bus.a_ready, bus.b_ready},
                  {vecs[k].ardy, vecs[k].brdy});
        end

        // Both requesters continuously valid: commits must alternate A,B,...
        do_reset();
        exp_seq = '{32'hA0, 32'hB0, 32'hA1, 32'hB1, 32'hA2, 32'hB2, 32'hA3, 32'hB3};
        a_n = 0; b_n = 0; commits = 0; prev_both_low = 1'b0;
        bus.a_valid = 1'b1; bus.a_reg = 3'd0; bus.a_data = 32'hA0;
        bus.b_valid = 1'b1; bus.b_reg = 3'd4; bus.b_data = 32'hB0;
        for (int cyc = 0; cyc < 9; cyc++) begin
            acc_a = bus.a_ready;
            acc_b = bus.b_ready;
            @(posedge clk); #1;
            if (acc_a) begin a_n++; bus.a_data = 32'hA0 + a_n; bus.a_reg = 3'(a_n); end
            if (acc_b) begin b_n++; bus.b_data = 32'hB0 + b_n; bus.b_reg = 3'(4 + b_n); end
            if (cyc >= 1) begin
                check($sformatf("alt%0d_srw", cyc - 1), bus.signal_reg_write, 1);
                check($sformatf("alt%0d_data", cyc - 1), bus.write_data, exp_seq[cyc-1]);
                if (bus.signal_reg_write) commits++;
            end
            if (!bus.a_ready && !bus.b_ready && prev_both_low)
                check($sformatf("alt%0d_ready_gap", cyc), 0, 1);
            prev_both_low = !bus.a_ready && !bus.b_ready;
        end
        check("alt_commits", commits, 8);
        idle_inputs();
        repeat (4) @(posedge clk);
        #1;
        check("alt_drained_pend", bus.pending, 0);

        // Accept then reset before the issue edge: nothing may commit.
        do_reset();
        bus.a_valid = 1'b1; bus.a_reg = 3'd4; bus.a_data = 32'hDEAD;
        @(posedge clk); #1;
        idle_inputs();
        check("rst_mid_pend_before", bus.pending, 8'h10);
        #2 reset = 1'b1;
        #1;
        check("rst_mid_pend", bus.pending, 0);
        check("rst_mid_srw", bus.signal_reg_write, 0);
        check("rst_mid_ready", {bus.a_ready, bus.b_ready}, 2'b11);
        @(posedge clk); #1;
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            check($sformatf("rst_after%0d_srw", c), bus.signal_reg_write, 0);
            check($sformatf("rst_after%0d_wdata", c), bus.write_data, 0);
            check($sformatf("rst_after%0d_pend", c), bus.pending, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
